serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes diff = a - b - bin over WIDTH cycles, LSB first,
//  using one full-subtractor cell and a registered borrow. It is the subtraction counterpart to the
//  ripple adder chain: area-cheap arithmetic for datapaths that can tolerate multi-cycle latency.
//  Operands arrive and results leave through valid/ready handshakes.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand presented
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result held on the outputs
//  out_ready  in   1      consumer takes result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out: 1 iff unsigned a < b + bin
//  ovf        out  1      signed overflow: borrow into MSB cell XOR borrow out of MSB cell
//  zero       out  1      diff == 0
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state=IDLE, counter=0, borrow reg=0, out_valid=0,
//   diff=0, bout=0, ovf=0, zero=0. in_ready is decoded from state, so it reads 1 during and after reset.
//  Reset mid-operation aborts the operation; the partial result is discarded, never presented.
//  FSM states and transitions:
//   IDLE : in_ready=1. On in_valid&&in_ready, latch a and b into shift regs, borrow<=bin, cnt<=0 -> SHIFT.
//   SHIFT: in_ready=0. Each cycle:
//     d = a0^b0^br
//     br' = (~a0&b0) | (~(a0^b0)&br)
//     shift a and b right; shift d in at the diff MSB end; cnt++
//     At cnt==WIDTH-1, keep the MSB-cell borrow-in for ovf.
//     After the WIDTH-th step, register bout, ovf and zero -> DONE.
//   DONE : out_valid=1. diff, bout, ovf and zero are stable.
//     On out_valid&&out_ready -> IDLE, out_valid drops on the next edge.
//     in_ready stays 0 in DONE, so there is no overlap of result hand-off and new accept.
//  Latency: out_valid rises exactly WIDTH cycles after the accepting edge.
//   Minimum initiation interval is WIDTH+2 cycles with out_ready tied high.
//  Inputs a, b and bin are sampled only on the accept edge; changes at other times have no effect.
//  Outputs hold the last result after the DONE->IDLE transition, until the next result or reset.
//  All arithmetic is modulo 2^WIDTH. Counter width is clog2(WIDTH)+1 and it never wraps mid-operation.
//  in_valid may stay high continuously; each accept consumes exactly one operand set.
// TESTING (WIDTH=8 unless noted)
//  1. a=0x05 b=0x03 bin=0 -> diff=0x02 bout=0 ovf=0 zero=0; out_valid exactly 8 cycles after accept.
//  2. a=0x03 b=0x05 bin=0 -> diff=0xFE bout=1 ovf=0.
//     a=0x80 b=0x01 -> diff=0x7F bout=0 ovf=1.
//     a=0x7F b=0xFF -> diff=0x80 bout=1 ovf=1.
//  3. a=0x10 b=0x0F bin=1 -> diff=0x00 zero=1 bout=0.
//     a=0x00 b=0x00 bin=1 -> diff=0xFF bout=1 ovf=0.
//  4. Hold out_ready low 5 cycles in DONE while pulsing in_valid with new operands:
//     outputs stay stable, in_ready=0, nothing accepted.
//     Then release out_ready: IDLE next cycle and the next accept is correct.
//  5. Drive rst_n low on the 3rd SHIFT cycle: out_valid=0 and in_ready=1 immediately, outputs zero.
//     The following operation a=0x44 b=0x11 -> diff=0x33.
//  6. WIDTH=8 and WIDTH=2: 1000 random operand sets with random out_ready stalls, checked against
//     a reference model of a-b-bin (diff, bout, ovf, zero).

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, LSB first, one full-subtractor
// cell and a registered borrow, with valid/ready handshakes on both sides.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_sh_nxt;
    logic             br;
    logic             br_nxt;
    logic             d_bit;
    logic [CW-1:0]    cnt;
    logic             last_step;

    // Full-subtractor cell on the current LSBs
    always_comb begin
        d_bit     = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt    = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        d_sh_nxt  = {d_bit, d_sh[WIDTH-1:1]};
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = SHIFT;
            SHIFT:   if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand shift registers, borrow, step counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            diff <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= d_sh_nxt;
                    br   <= br_nxt;
                    cnt  <= cnt + CW'(1);
                    // On the last step br is the borrow into the MSB cell
                    if (last_step) begin
                        diff <= d_sh_nxt;
                        bout <= br_nxt;
                        ovf  <= br ^ br_nxt;
                        zero <= (d_sh_nxt == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table, handshake/reset corner
// sequences, and random operands on WIDTH=8 and WIDTH=2 against an arithmetic model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       iv8, ir8, bin8, ov8, or8, bo8, ovf8, z8;
    logic [7:0] a8, b8, d8;
    logic       iv2, ir2, bin2, ov2, or2, bo2, ovf2, z2;
    logic [1:0] a2, b2, d2;

    int nvec = 0;
    int nerr = 0;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .ovf(ovf8), .zero(z8)
    );

    serial_subtractor #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .bin(bin2),
        .out_valid(ov2), .out_ready(or2), .diff(d2), .bout(bo2), .ovf(ovf2), .zero(z2)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic; returns {zero, ovf, bout, diff[7:0]}
    function automatic logic [10:0] model(input int w, input int a, input int b, input int bin);
        int   m  = 1 << w;
        int   h  = m / 2;
        int   r  = a - b - bin;
        int   d  = ((r % m) + m) % m;
        int   sa = (a >= h) ? a - m : a;
        int   sb = (b >= h) ? b - m : b;
        int   sr = sa - sb - bin;
        logic ov = (sr < -h) || (sr >= h);
        return {logic'(d == 0), ov, logic'(r < 0), 8'(d)};
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input int stall,
                       input logic release_out, output logic [10:0] res, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!ir8 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ir8) begin
            nvec++; nerr++;
            $display("FAIL ready8_timeout: in_ready stayed 0");
        end
        iv8 = 1'b1; a8 = a; b8 = b; bin8 = bin; or8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        end
        if (!ov8) begin
            nvec++; nerr++;
            $display("FAIL valid8_timeout: out_valid stayed 0");
        end
        res = {z8, ovf8, bo8, d8};
        if (release_out) begin
            repeat (stall) @(posedge clk);
            #1 or8 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0;
        end
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bin, input int stall,
                       output logic [10:0] res, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!ir2 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ir2) begin
            nvec++; nerr++;
            $display("FAIL ready2_timeout: in_ready stayed 0");
        end
        iv2 = 1'b1; a2 = a; b2 = b; bin2 = bin; or2 = 1'b0;
        @(posedge clk); #1;
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            a2 = 2'($urandom); b2 = 2'($urandom); bin2 = 1'($urandom);
        end
        if (!ov2) begin
            nvec++; nerr++;
            $display("FAIL valid2_timeout: out_valid stayed 0");
        end
        res = {z2, ovf2, bo2, 6'b0, d2};
        repeat (stall) @(posedge clk);
        #1 or2 = 1'b1;
        @(posedge clk); #1;
        or2 = 1'b0;
    endtask

    initial begin
        vec_t        vecs[11];
        logic [10:0] res;
        logic [10:0] exp;
        int          lat;
        logic [7:0]  ra, rb;
        logic        rbin;

        vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; or8 = 1'b0;
        iv2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0; or2 = 1'b0;
        #12;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_outputs", 32'({d8, bo8, ovf8, z8}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors
        foreach (vecs[i]) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].bin, 0, 1'b1, res, lat);
            chk($sformatf("vec%0d_diff", i), 32'(res[7:0]), 32'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(res[8]), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_ovf", i), 32'(res[9]), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_zero", i), 32'(res[10]), 32'(vecs[i].z));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
        end

        // Stall in DONE while new operands are offered
        op8(8'h20, 8'h05, 1'b0, 0, 1'b0, res, lat);
        chk("stall_first", 32'(res), 32'({1'b0, 1'b0, 1'b0, 8'h1B}));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            iv8 = 1'(k % 2 == 0); a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            @(negedge clk);
            chk("stall_out_valid", 32'(ov8), 32'd1);
            chk("stall_in_ready", 32'(ir8), 32'd0);
            chk("stall_hold", 32'({z8, ovf8, bo8, d8}), 32'({1'b0, 1'b0, 1'b0, 8'h1B}));
        end
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        chk("release_idle", 32'({ov8, ir8}), 32'b01);
        chk("release_hold", 32'(d8), 32'h1B);
        op8(8'h09, 8'h0A, 1'b1, 0, 1'b1, res, lat);
        chk("after_stall", 32'(res), 32'({1'b0, 1'b0, 1'b1, 8'hFE}));

        // Reset on the third SHIFT cycle
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov8), 32'd0);
        chk("midrst_in_ready", 32'(ir8), 32'd1);
        chk("midrst_outputs", 32'({d8, bo8, ovf8, z8}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("midrst_no_result", 32'(ov8), 32'd0);
        op8(8'h44, 8'h11, 1'b0, 0, 1'b1, res, lat);
        chk("post_rst_op", 32'(res), 32'({1'b0, 1'b0, 1'b0, 8'h33}));

        // Random operands, WIDTH=8
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            op8(ra, rb, rbin, int'($urandom_range(0, 3)), 1'b1, res, lat);
            exp = model(8, int'(ra), int'(rb), int'(rbin));
            if (res !== exp || lat != 8) begin
                nerr++;
                $display("FAIL rnd8 a=%0h b=%0h bin=%0b: got %0h lat %0d expected %0h lat 8",
                         ra, rb, rbin, res, lat, exp);
            end
            nvec++;
        end

        // Random operands, WIDTH=2
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 3)); rb = 8'($urandom_range(0, 3)); rbin = 1'($urandom);
            op2(ra[1:0], rb[1:0], rbin, int'($urandom_range(0, 3)), res, lat);
            exp = model(2, int'(ra), int'(rb), int'(rbin));
            if (res !== exp || lat != 2) begin
                nerr++;
                $display("FAIL rnd2 a=%0h b=%0h bin=%0b: got %0h lat %0d expected %0h lat 2",
                         ra, rb, rbin, res, lat, exp);
            end
            nvec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
